ddr_cmd_engine: RTL and testbench
=================================

# ddr_cmd_engine

Command responder on the DDR side of the request FIFO. It accepts one queued command at a time (read `4'b0011` or write `4'b0100`, 25-bit address, 128-bit data) and executes it on the memory controller's native command/data port. It holds `cmd_busy` while a command is in flight and returns read data as a single-cycle `ddr_data_valid` pulse. It also runs the controller initialisation handshake and publishes `init_done` to the request side.

## Interface
Parameters:
- `RD_TIMEOUT`, 255: cycles waited for read data before a timeout response is forced.

Ports:
- `clk_133M`  in  1  system clock. One clock only.
- `rst_n_133M`  in  1  synchronous, active-low reset.
- `cmd`  in  4  command code: `0011` read, `0100` write, anything else invalid.
- `cmd_valid`  in  1  single-cycle command strobe.
- `ddr_address`  in  25  command address.
- `ddr_wr_data`  in  128  write payload.
- `cmd_busy`  out  1  engine not accepting commands.
- `ddr_rd_data`  out  128  read data returned upstream.
- `ddr_data_valid`  out  1  one-cycle read-return strobe.
- `init_done`  out  1  controller initialised; sticky until reset.
- `rd_timeout_err`  out  1  sticky flag: a read timed out.
- `mc_init_start`  out  1  init request to the controller.
- `mc_init_done`  in  1  controller init complete.
- `mc_cmd`  out  4  native command: `0001` read, `0010` write.
- `mc_cmd_valid`  out  1  native command request.
- `mc_addr`  out  25  native address.
- `mc_cmd_rdy`  in  1  controller takes the command this cycle.
- `mc_datain_rdy`  in  1  controller takes `mc_write_data` this cycle.
- `mc_write_data`  out  128  write data.
- `mc_read_data`  in  128  read data.
- `mc_read_data_valid`  in  1  read data strobe.

## Operation
- States: `INIT`, `IDLE`, `ISSUE`, `WR_DATA`, `RD_WAIT`, `DONE`.
- **Reset values:** state `INIT`, `cmd_busy` 1, `mc_init_start` 0, and every other output 0, including the data buses.
- **`INIT`**
  - `mc_init_start` is high from the first cycle after reset release until `mc_init_done` is sampled high; it then drops.
  - `init_done` rises on the next cycle and the FSM moves to `IDLE`.
  - `cmd_valid` is ignored in this state.
- **`IDLE`**
  - `cmd_busy` is 0.
  - On `cmd_valid`, the engine latches `cmd`, `ddr_address` and `ddr_wr_data`.
  - Read or write: go to `ISSUE`. Invalid code: go to `DONE` with no memory access.
- **`ISSUE`**
  - `mc_cmd_valid` is 1, with `mc_cmd` and `mc_addr` taken from the latched values. They hold until `mc_cmd_rdy` is sampled high.
  - The FSM then moves to `WR_DATA` for a write or `RD_WAIT` for a read.
  - `mc_cmd_valid` drops the same edge.
- **`WR_DATA`**
  - `mc_write_data` carries the latched payload.
  - When `mc_datain_rdy` is sampled high, go to `DONE`.
- **`RD_WAIT`**
  - A timeout counter, `$clog2(RD_TIMEOUT+1)` bits wide, clears on entry and increments each cycle.
  - On `mc_read_data_valid`, `ddr_rd_data` <= `mc_read_data` and `ddr_data_valid` pulses for one cycle; go to `DONE`.
  - If the counter reaches `RD_TIMEOUT` first, `ddr_rd_data` <= 0, `ddr_data_valid` pulses, `rd_timeout_err` <= 1, go to `DONE`. Every accepted read produces exactly one upstream response, which keeps the upstream routing FIFO aligned.
- **`DONE`**: one cycle, then `IDLE`.
- **Unsolicited data:** `mc_read_data_valid` outside `RD_WAIT` is ignored and produces no upstream pulse.
- **Protocol violation:** `cmd_valid` while `cmd_busy`=1 is ignored. The in-flight command is unaffected.
- **Reset mid-operation:** the engine returns to `INIT` and re-runs controller init. Pending reads are dropped with no response.

## Timing
- **`cmd_busy`:** registered. It is high from the cycle after `cmd_valid` is accepted through the `DONE` cycle inclusive, and low again the cycle after `DONE`. This satisfies an upstream that suppresses its next read while `cmd_valid` is high.
- **Accept → `mc_cmd_valid`:** 1 cycle.
- **Write, zero-wait controller:** accept at cycle 0 → `mc_cmd_valid` at 1 → `WR_DATA` at 2 → `DONE` at 3 → `cmd_busy` low at 4.
- **Read:** `mc_read_data_valid` at cycle N → `ddr_data_valid` at N+1 → `cmd_busy` low at N+3.
- **Timeout:** `ddr_data_valid` fires `RD_TIMEOUT`+1 cycles after entering `RD_WAIT`.
- **Throughput:** at most one command per 4 cycles.

## Test plan
- **Init:** release reset, drive `mc_init_done` high 20 cycles later → `mc_init_start` high for cycles 1–20 and low after; `init_done` rises the cycle after `mc_init_done`; `cmd_valid` pulses before that are ignored.
- **Write:** `cmd`=`0100`, address `0x0ABCDEF`, data `128'h0123…CDEF`; `mc_cmd_rdy` delayed 3 cycles, `mc_datain_rdy` delayed 2 → `mc_cmd`=`0010` and `mc_addr`=`0x0ABCDEF` held 4 cycles; `mc_write_data` equals the payload; `cmd_busy` low 2 cycles after `mc_datain_rdy`.
- **Read:** `cmd`=`0011`, address `0x1000000`; `mc_read_data`=`128'hA5…A5` valid 10 cycles after command handshake → one `ddr_data_valid` pulse with `ddr_rd_data`=`A5…A5`; `rd_timeout_err` stays 0.
- **Timeout:** read with no `mc_read_data_valid` → `ddr_data_valid` with data 0 exactly 256 cycles after entering `RD_WAIT`; `rd_timeout_err`=1 and sticky; a later read completes normally.
- **Violations:**
  - `cmd_valid` during a busy read: no second `mc_cmd_valid`.
  - `cmd`=`0111`: `cmd_busy` high 1 cycle, no `mc_cmd_valid`.
  - Stray `mc_read_data_valid` while `IDLE`: no `ddr_data_valid`.
- **Reset mid-read:** assert `rst_n_133M` low during `RD_WAIT` → all outputs at reset values the next cycle, `init_done`=0; late `mc_read_data_valid` produces no response.

Source files
------------

// File: rtl/ddr_cmd_engine_if.sv
// Signal bundle between the request FIFO, ddr_cmd_engine and the memory controller.
// slave is the engine's view of the bundle; master is the environment that drives it.
interface ddr_cmd_engine_if;
    logic [3:0]   cmd;
    logic         cmd_valid;
    logic [24:0]  ddr_address;
    logic [127:0] ddr_wr_data;
    logic         cmd_busy;
    logic [127:0] ddr_rd_data;
    logic         ddr_data_valid;
    logic         init_done;
    logic         rd_timeout_err;
    logic         mc_init_start;
    logic         mc_init_done;
    logic [3:0]   mc_cmd;
    logic         mc_cmd_valid;
    logic [24:0]  mc_addr;
    logic         mc_cmd_rdy;
    logic         mc_datain_rdy;
    logic [127:0] mc_write_data;
    logic [127:0] mc_read_data;
    logic         mc_read_data_valid;

    modport slave (
        input  cmd, cmd_valid, ddr_address, ddr_wr_data,
        input  mc_init_done, mc_cmd_rdy, mc_datain_rdy, mc_read_data, mc_read_data_valid,
        output cmd_busy, ddr_rd_data, ddr_data_valid, init_done, rd_timeout_err,
        output mc_init_start, mc_cmd, mc_cmd_valid, mc_addr, mc_write_data
    );

    modport master (
        output cmd, cmd_valid, ddr_address, ddr_wr_data,
        output mc_init_done, mc_cmd_rdy, mc_datain_rdy, mc_read_data, mc_read_data_valid,
        input  cmd_busy, ddr_rd_data, ddr_data_valid, init_done, rd_timeout_err,
        input  mc_init_start, mc_cmd, mc_cmd_valid, mc_addr, mc_write_data
    );
endinterface

// File: rtl/ddr_cmd_engine.sv
// Executes one queued read/write at a time on the controller's native port,
// runs the controller init handshake and returns read data (or a timeout response) upstream.
module ddr_cmd_engine #(
    parameter int RD_TIMEOUT = 255
) (
    input  logic                   clk_133M,
    input  logic                   rst_n_133M,
    ddr_cmd_engine_if.slave        bus
);
    localparam int              CNT_W       = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(RD_TIMEOUT);
    localparam logic [3:0]      CMD_RD      = 4'b0011;
    localparam logic [3:0]      CMD_WR      = 4'b0100;
    localparam logic [3:0]      MC_RD       = 4'b0001;
    localparam logic [3:0]      MC_WR       = 4'b0010;

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, WR_DATA, RD_WAIT, DONE} state_t;

    state_t           r_state;
    logic             r_is_rd;
    logic             r_rd_resp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd_busy;
    logic [127:0]     r_ddr_rd_data;
    logic             r_ddr_data_valid;
    logic             r_init_done;
    logic             r_rd_timeout_err;
    logic             r_mc_init_start;
    logic [3:0]       r_mc_cmd;
    logic             r_mc_cmd_valid;
    logic [24:0]      r_mc_addr;
    logic [127:0]     r_mc_write_data;

    logic w_is_rd;
    logic w_is_wr;
    logic w_timeout;

    assign w_is_rd   = (bus.cmd == CMD_RD);
    assign w_is_wr   = (bus.cmd == CMD_WR);
    assign w_timeout = (r_cnt == TIMEOUT_VAL);

    // NOTE: all state lives in this one clocked block and uses <= so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk_133M) begin
        if (!rst_n_133M) begin
            r_state          <= INIT;
            r_is_rd          <= 1'b0;
            r_rd_resp        <= 1'b0;
            r_cnt            <= '0;
            r_cmd_busy       <= 1'b1;
            r_ddr_rd_data    <= '0;
            r_ddr_data_valid <= 1'b0;
            r_init_done      <= 1'b0;
            r_rd_timeout_err <= 1'b0;
            r_mc_init_start  <= 1'b0;
            r_mc_cmd         <= '0;
            r_mc_cmd_valid   <= 1'b0;
            r_mc_addr        <= '0;
            r_mc_write_data  <= '0;
        end else begin
            // NOTE: default-low assignment makes ddr_data_valid a one-cycle pulse.
            r_ddr_data_valid <= 1'b0;
            case (r_state)
                INIT: begin
                    if (bus.mc_init_done) begin
                        r_mc_init_start <= 1'b0;
                        r_init_done     <= 1'b1;
                        r_cmd_busy      <= 1'b0;
                        r_state         <= IDLE;
                    end else begin
                        r_mc_init_start <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_cmd_busy <= 1'b1;
                        r_is_rd    <= w_is_rd;
                        if (w_is_rd || w_is_wr) begin
                            r_mc_cmd       <= w_is_rd ? MC_RD : MC_WR;
                            r_mc_addr      <= bus.ddr_address;
                            r_mc_cmd_valid <= 1'b1;
                            if (w_is_wr) r_mc_write_data <= bus.ddr_wr_data;
                            r_state        <= ISSUE;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mc_cmd_rdy) begin
                        r_mc_cmd_valid <= 1'b0;
                        r_cnt          <= '0;
                        r_rd_resp      <= 1'b0;
                        r_state        <= r_is_rd ? RD_WAIT : WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (bus.mc_datain_rdy) r_state <= DONE;
                end
                RD_WAIT: begin
                    // The response goes out one cycle before DONE so busy drops at N+3.
                    if (r_rd_resp) begin
                        r_state <= DONE;
                    end else if (bus.mc_read_data_valid) begin
                        r_ddr_rd_data    <= bus.mc_read_data;
                        r_ddr_data_valid <= 1'b1;
                        r_rd_resp        <= 1'b1;
                    end else if (w_timeout) begin
                        r_ddr_rd_data    <= '0;
                        r_ddr_data_valid <= 1'b1;
                        r_rd_timeout_err <= 1'b1;
                        r_rd_resp        <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_cmd_busy <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign bus.cmd_busy       = r_cmd_busy;
    assign bus.ddr_rd_data    = r_ddr_rd_data;
    assign bus.ddr_data_valid = r_ddr_data_valid;
    assign bus.init_done      = r_init_done;
    assign bus.rd_timeout_err = r_rd_timeout_err;
    assign bus.mc_init_start  = r_mc_init_start;
    assign bus.mc_cmd         = r_mc_cmd;
    assign bus.mc_cmd_valid   = r_mc_cmd_valid;
    assign bus.mc_addr        = r_mc_addr;
    assign bus.mc_write_data  = r_mc_write_data;
endmodule

// File: tb/tb_ddr_cmd_engine.sv
// Self-checking bench for ddr_cmd_engine: a transaction-level model predicts every output
// each cycle from recorded event cycles; directed scenarios add hand-computed checks.
module tb_ddr_cmd_engine;
    localparam int          RD_TIMEOUT = 255;
    localparam logic [3:0]  CMD_RD     = 4'b0011;
    localparam logic [3:0]  CMD_WR     = 4'b0100;
    localparam logic [127:0] PAYLOAD   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] PAT_A5    = {16{8'hA5}};
    localparam logic [127:0] PAT_RD2   = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ddr_cmd_engine_if ifc ();
    ddr_cmd_engine #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk_133M  (clk),
        .rst_n_133M(rst_n),
        .bus       (ifc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: remember the cycle of each event; expectations follow by arithmetic.
    int  cyc      = 0;
    bit  started  = 0;
    int  rel_cyc  = -1;
    int  init_cyc = -1;
    bit  t_act, t_rd, t_wr;
    int  t_a, t_h, t_d, t_r;
    logic [3:0]   t_mccmd;
    logic [24:0]  t_addr;
    logic [127:0] t_wdata;
    logic [127:0] rd_cur, rd_prev;
    int  rd_sw, err_sw;

    function automatic int txn_end();
        if (!t_rd && !t_wr) return t_a + 1;
        if (t_wr) return (t_d < 0) ? -1 : t_d + 1;
        return (t_r < 0) ? -1 : t_r + 2;
    endfunction

    function automatic bit eng_free(input int c);
        int e;
        if (init_cyc < 0 || c <= init_cyc) return 1'b0;
        if (!t_act) return 1'b1;
        e = txn_end();
        return (e >= 0 && c > e);
    endfunction

    function automatic bit exp_cmdv(input int c);
        return t_act && (t_rd || t_wr) && c > t_a && (t_h < 0 || c <= t_h);
    endfunction

    function automatic bit exp_wrph(input int c);
        return t_act && t_wr && t_h >= 0 && c > t_h && (t_d < 0 || c <= t_d);
    endfunction

    function automatic bit exp_rdwait(input int c);
        return t_act && t_rd && t_h >= 0 && c > t_h && t_r < 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            started = 1; rel_cyc = -1; init_cyc = -1; t_act = 0;
            rd_cur = '0; rd_prev = '0; rd_sw = 0; err_sw = -1;
        end else if (started) begin
            if (rel_cyc < 0) rel_cyc = cyc;
            if (init_cyc < 0 && ifc.mc_init_done) init_cyc = cyc;
            if (exp_cmdv(cyc) && ifc.mc_cmd_rdy) begin
                t_h = cyc;
            end else if (exp_wrph(cyc) && ifc.mc_datain_rdy) begin
                t_d = cyc;
            end else if (exp_rdwait(cyc)) begin
                if (ifc.mc_read_data_valid || cyc == t_h + 1 + RD_TIMEOUT) begin
                    t_r = cyc;
                    rd_prev = rd_cur;
                    rd_cur  = ifc.mc_read_data_valid ? ifc.mc_read_data : '0;
                    rd_sw   = cyc + 1;
                    if (!ifc.mc_read_data_valid && err_sw < 0) err_sw = cyc + 1;
                end
            end
            if (ifc.cmd_valid && eng_free(cyc)) begin
                t_act = 1; t_a = cyc; t_h = -1; t_d = -1; t_r = -1;
                t_rd = (ifc.cmd == CMD_RD); t_wr = (ifc.cmd == CMD_WR);
                t_mccmd = t_rd ? 4'b0001 : 4'b0010;
                t_addr = ifc.ddr_address; t_wdata = ifc.ddr_wr_data;
            end
        end
        cyc++;
    end

    // Single compare process: every output, every cycle, against the model.
    always @(negedge clk) begin
        if (started) begin
            if (rel_cyc < 0) begin
                check("rst_busy", 128'(ifc.cmd_busy), 128'(1'b1));
                check("rst_init_start", 128'(ifc.mc_init_start), '0);
                check("rst_init_done", 128'(ifc.init_done), '0);
                check("rst_err", 128'(ifc.rd_timeout_err), '0);
                check("rst_dv", 128'(ifc.ddr_data_valid), '0);
                check("rst_rd_data", ifc.ddr_rd_data, '0);
                check("rst_cmdv", 128'(ifc.mc_cmd_valid), '0);
                check("rst_mc_cmd", 128'(ifc.mc_cmd), '0);
                check("rst_mc_addr", 128'(ifc.mc_addr), '0);
                check("rst_wdata", ifc.mc_write_data, '0);
            end else begin
                check("m_busy", 128'(ifc.cmd_busy), 128'(!eng_free(cyc)));
                check("m_init_done", 128'(ifc.init_done), 128'(init_cyc >= 0 && cyc > init_cyc));
                check("m_init_start", 128'(ifc.mc_init_start),
                      128'(cyc > rel_cyc && (init_cyc < 0 || cyc <= init_cyc)));
                check("m_cmdv", 128'(ifc.mc_cmd_valid), 128'(exp_cmdv(cyc)));
                if (exp_cmdv(cyc)) begin
                    check("m_mc_cmd", 128'(ifc.mc_cmd), 128'(t_mccmd));
                    check("m_mc_addr", 128'(ifc.mc_addr), 128'(t_addr));
                end
                if (exp_wrph(cyc)) check("m_wdata", ifc.mc_write_data, t_wdata);
                check("m_dv", 128'(ifc.ddr_data_valid),
                      128'(t_act && t_rd && t_r >= 0 && cyc == t_r + 1));
                check("m_rd_data", ifc.ddr_rd_data, (cyc >= rd_sw) ? rd_cur : rd_prev);
                check("m_err", 128'(ifc.rd_timeout_err), 128'(err_sw >= 0 && cyc >= err_sw));
            end
        end
    end

    // Event counters consumed by the directed checks.
    int start_cnt = 0, mcv_cnt = 0, dv_cnt = 0;
    always @(negedge clk) begin
        if (ifc.mc_init_start === 1'b1) start_cnt++;
        if (ifc.mc_cmd_valid === 1'b1) mcv_cnt++;
        if (ifc.ddr_data_valid === 1'b1) dv_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [24:0] a, input logic [127:0] d);
        ifc.cmd = c; ifc.ddr_address = a; ifc.ddr_wr_data = d; ifc.cmd_valid = 1'b1;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        ifc.cmd = '0; ifc.cmd_valid = 0; ifc.ddr_address = '0; ifc.ddr_wr_data = '0;
        ifc.mc_init_done = 0; ifc.mc_cmd_rdy = 0; ifc.mc_datain_rdy = 0;
        ifc.mc_read_data = '0; ifc.mc_read_data_valid = 0;
        step(3);

        // Init: mc_init_done 20 cycles after release; a command during init is ignored.
        rst_n = 1'b1;
        step(4);
        issue(CMD_WR, 25'h0000055, PAYLOAD);
        step(1);
        ifc.cmd_valid = 0;
        step(15);
        ifc.mc_init_done = 1;
        @(negedge clk);
        check("init_done_early", 128'(ifc.init_done), '0);
        step(1);
        ifc.mc_init_done = 0;
        @(negedge clk);
        check("init_done_rise", 128'(ifc.init_done), 128'(1'b1));
        step(1);
        check("init_start_cycles", 128'(start_cnt), 128'(20));
        check("init_no_cmd", 128'(mcv_cnt), '0);

        // Write with mc_cmd_rdy 3 cycles late and mc_datain_rdy 2 cycles late.
        step(1);
        issue(CMD_WR, 25'h0ABCDEF, PAYLOAD);
        mcv_cnt = 0;
        step(1);
        ifc.cmd_valid = 0;
        step(3);
        ifc.mc_cmd_rdy = 1;
        step(1);
        ifc.mc_cmd_rdy = 0;
        @(negedge clk);
        check("wr_payload", ifc.mc_write_data, PAYLOAD);
        step(2);
        ifc.mc_datain_rdy = 1;
        step(1);
        ifc.mc_datain_rdy = 0;
        @(negedge clk);
        check("wr_busy_done", 128'(ifc.cmd_busy), 128'(1'b1));
        step(1);
        @(negedge clk);
        check("wr_busy_low", 128'(ifc.cmd_busy), '0);
        check("wr_cmd_hold", 128'(mcv_cnt), 128'(4));

        // Read with data 10 cycles after the handshake; a second command mid-read is ignored.
        step(2);
        issue(CMD_RD, 25'h1000000, '0);
        mcv_cnt = 0; dv_cnt = 0;
        step(1);
        ifc.cmd_valid = 0; ifc.mc_cmd_rdy = 1;
        step(1);
        ifc.mc_cmd_rdy = 0;
        step(2);
        issue(CMD_WR, 25'h0000777, PAYLOAD);
        step(1);
        ifc.cmd_valid = 0;
        step(6);
        ifc.mc_read_data = PAT_A5; ifc.mc_read_data_valid = 1;
        step(1);
        ifc.mc_read_data_valid = 0; ifc.mc_read_data = '1;
        @(negedge clk);
        check("rd_dv", 128'(ifc.ddr_data_valid), 128'(1'b1));
        check("rd_data", ifc.ddr_rd_data, PAT_A5);
        step(1);
        @(negedge clk);
        check("rd_busy_done", 128'(ifc.cmd_busy), 128'(1'b1));
        step(1);
        @(negedge clk);
        check("rd_busy_low", 128'(ifc.cmd_busy), '0);
        check("rd_no_err", 128'(ifc.rd_timeout_err), '0);
        check("rd_one_cmd", 128'(mcv_cnt), 128'(1));
        check("rd_one_resp", 128'(dv_cnt), 128'(1));

        // Invalid command: one busy cycle, no memory access.
        step(2);
        issue(4'b0111, 25'h0000001, '0);
        mcv_cnt = 0;
        step(1);
        ifc.cmd_valid = 0;
        @(negedge clk);
        check("inv_busy", 128'(ifc.cmd_busy), 128'(1'b1));
        step(1);
        @(negedge clk);
        check("inv_busy_low", 128'(ifc.cmd_busy), '0);
        check("inv_no_cmd", 128'(mcv_cnt), '0);

        // Stray read data while idle.
        step(1);
        dv_cnt = 0;
        ifc.mc_read_data = PAT_RD2; ifc.mc_read_data_valid = 1;
        step(1);
        ifc.mc_read_data_valid = 0;
        step(3);
        check("stray_no_resp", 128'(dv_cnt), '0);

        // Read timeout: response with zero data RD_TIMEOUT+1 cycles after entering RD_WAIT.
        issue(CMD_RD, 25'h0000123, '0);
        step(1);
        ifc.cmd_valid = 0; ifc.mc_cmd_rdy = 1;
        step(1);
        ifc.mc_cmd_rdy = 0;
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ifc.ddr_data_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("to_latency", 128'(lat), 128'(256));
        check("to_data", ifc.ddr_rd_data, '0);
        check("to_err", 128'(ifc.rd_timeout_err), 128'(1'b1));
        step(5);

        // A normal read after the timeout; the error flag stays set.
        issue(CMD_RD, 25'h1FFFFFF, '0);
        step(1);
        ifc.cmd_valid = 0; ifc.mc_cmd_rdy = 1;
        step(1);
        ifc.mc_cmd_rdy = 0;
        step(2);
        ifc.mc_read_data = PAT_RD2; ifc.mc_read_data_valid = 1;
        step(1);
        ifc.mc_read_data_valid = 0;
        @(negedge clk);
        check("rd2_data", ifc.ddr_rd_data, PAT_RD2);
        check("err_sticky", 128'(ifc.rd_timeout_err), 128'(1'b1));

        // Reset during RD_WAIT; the late read data must produce no response.
        step(3);
        issue(CMD_RD, 25'h0000ABC, '0);
        step(1);
        ifc.cmd_valid = 0; ifc.mc_cmd_rdy = 1;
        step(1);
        ifc.mc_cmd_rdy = 0;
        step(4);
        rst_n = 1'b0;
        step(1);
        @(negedge clk);
        check("rst_mid_init_done", 128'(ifc.init_done), '0);
        check("rst_mid_busy", 128'(ifc.cmd_busy), 128'(1'b1));
        check("rst_mid_err", 128'(ifc.rd_timeout_err), '0);
        step(1);
        rst_n = 1'b1;
        dv_cnt = 0;
        step(2);
        ifc.mc_read_data = PAT_A5; ifc.mc_read_data_valid = 1;
        step(1);
        ifc.mc_read_data_valid = 0;
        step(5);
        ifc.mc_init_done = 1;
        step(1);
        ifc.mc_init_done = 0;
        step(2);
        check("rst_late_no_resp", 128'(dv_cnt), '0);
        check("reinit_done", 128'(ifc.init_done), 128'(1'b1));

        // Zero-wait write after re-init.
        issue(CMD_WR, 25'h0012345, PAT_RD2);
        step(1);
        ifc.cmd_valid = 0; ifc.mc_cmd_rdy = 1;
        step(1);
        ifc.mc_cmd_rdy = 0; ifc.mc_datain_rdy = 1;
        step(1);
        ifc.mc_datain_rdy = 0;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
